tmds_decoder: RTL and testbench

Receive-side counterpart of the HDMI TMDS encoder: takes raw, unaligned 10-bit words from a 1:10 deserializer on one TMDS channel, finds word alignment with a bit-slip search, and recovers the 8-bit pixel data, the 2-bit control (HSYNC/VSYNC) value and the video-enable flag. It sits between the deserializer and any downstream capture or frame-buffer writer. It lets the pixel pipeline be looped back over HDMI and checked on the board.

---
 rtl/tmds_pkg.sv | 21 ++
 rtl/tmds_word_align.sv | 26 ++
 rtl/tmds_decoder.sv | 115 +++++++++++
 tb/tb_tmds_decoder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// tmds_pkg: shared TMDS control tokens, decoder state and data-decode helper
package tmds_pkg;

    localparam logic [9:0] TOKEN_C00 = 10'b1101010100;
    localparam logic [9:0] TOKEN_C01 = 10'b0010101011;
    localparam logic [9:0] TOKEN_C10 = 10'b0101010100;
    localparam logic [9:0] TOKEN_C11 = 10'b1010101011;

    typedef enum logic {SEARCH, LOCKED} tmds_state_e;

    function automatic logic [7:0] tmds_decode_data(input logic [9:0] w);
        logic [7:0] q;
        logic [7:0] d;
        q = w[9] ? ~w[7:0] : w[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++)
            d[i] = w[8] ? q[i] ^ q[i-1] : ~(q[i] ^ q[i-1]);
        return d;
    endfunction

endpackage

// File: rtl/tmds_word_align.sv
// tmds_word_align: previous-word register and 10:1 bit-slip selector with registered output
module tmds_word_align (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [9:0] tmds_in,
    input  logic [3:0] slip,
    output logic [9:0] word_out
);

    logic [9:0]  prev;
    logic [19:0] both;

    assign both = {tmds_in, prev};

    // older word occupies the low half, so slip selects how many of its bits are skipped
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            prev     <= '0;
            word_out <= '0;
        end else begin
            prev     <= tmds_in;
            word_out <= 10'(both >> slip);
        end
    end

endmodule

// File: rtl/tmds_decoder.sv
// tmds_decoder: TMDS channel receiver with bit-slip alignment search and 8b/2b decode
module tmds_decoder #(
    parameter int CTRL_LOCK_COUNT = 8,
    parameter int SEARCH_WINDOW   = 1024,
    parameter int LOCK_TIMEOUT    = 2048
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [9:0] tmds_in,
    output logic [7:0] data_out,
    output logic [1:0] control_out,
    output logic       ve_out,
    output logic       valid_out,
    output logic [3:0] slip_out,
    output logic [7:0] lock_loss_out
);

    import tmds_pkg::*;

    localparam int RW = $clog2(CTRL_LOCK_COUNT + 1);
    localparam int WW = $clog2(SEARCH_WINDOW);
    localparam int TW = $clog2(LOCK_TIMEOUT);

    tmds_state_e state, state_nxt;
    logic [9:0]    word, last_word;
    logic [RW-1:0] run, run_nxt;
    logic [WW-1:0] win, win_nxt;
    logic [TW-1:0] tmo, tmo_nxt;
    logic [3:0]    slip_nxt;
    logic [7:0]    loss_nxt;
    logic [1:0]    tok_val;
    logic          is_tok, run_hit, slip_chg, skip, ve_q;

    tmds_word_align u_align (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .tmds_in (tmds_in),
        .slip    (slip_out),
        .word_out(word)
    );

    assign is_tok  = word inside {TOKEN_C00, TOKEN_C01, TOKEN_C10, TOKEN_C11};
    assign tok_val = (word == TOKEN_C01) ? 2'b01 :
                     (word == TOKEN_C10) ? 2'b10 :
                     (word == TOKEN_C11) ? 2'b11 : 2'b00;
    assign run_nxt = (skip || !is_tok)                ? '0 :
                     (word != last_word)              ? RW'(1) :
                     (run == RW'(CTRL_LOCK_COUNT))    ? run : run + 1'b1;
    assign run_hit   = run_nxt == RW'(CTRL_LOCK_COUNT);
    assign valid_out = state == LOCKED;
    assign ve_out    = ve_q & valid_out;

    // next state: lock beats window expiry; lock loss and window expiry both advance the slip
    always_comb begin
        state_nxt = state;
        win_nxt   = '0;
        tmo_nxt   = '0;
        loss_nxt  = lock_loss_out;
        slip_chg  = 1'b0;
        if (state == SEARCH) begin
            if (run_hit)
                state_nxt = LOCKED;
            else if (win == WW'(SEARCH_WINDOW - 1))
                slip_chg = 1'b1;
            else
                win_nxt = win + 1'b1;
        end else if (!run_hit) begin
            if (tmo == TW'(LOCK_TIMEOUT - 1)) begin
                state_nxt = SEARCH;
                slip_chg  = 1'b1;
                loss_nxt  = (lock_loss_out == 8'hFF) ? lock_loss_out : lock_loss_out + 8'd1;
            end else begin
                tmo_nxt = tmo + 1'b1;
            end
        end
        slip_nxt = !slip_chg ? slip_out : (slip_out == 4'd9) ? 4'd0 : slip_out + 4'd1;
    end

    // state, counters and slip; the word straddling a slip change is excluded from the run
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state         <= SEARCH;
            run           <= '0;
            win           <= '0;
            tmo           <= '0;
            slip_out      <= '0;
            lock_loss_out <= '0;
            skip          <= 1'b0;
            last_word     <= '0;
        end else begin
            state         <= state_nxt;
            run           <= slip_chg ? '0 : run_nxt;
            win           <= win_nxt;
            tmo           <= tmo_nxt;
            slip_out      <= slip_nxt;
            lock_loss_out <= loss_nxt;
            skip          <= slip_chg;
            last_word     <= word;
        end
    end

    // decode register; control value persists through video periods
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            data_out    <= '0;
            control_out <= '0;
            ve_q        <= 1'b0;
        end else begin
            data_out    <= tmds_decode_data(word);
            control_out <= is_tok ? tok_val : control_out;
            ve_q        <= !is_tok;
        end
    end

endmodule

// File: tb/tb_tmds_decoder.sv
// tb_tmds_decoder: directed scoreboard bench for tmds_decoder with a reference TMDS encoder
module tb_tmds_decoder;

    localparam int CLC = 8;
    localparam int SW  = 64;
    localparam int LT  = 128;

    localparam logic [9:0] T00 = 10'b1101010100;
    localparam logic [9:0] T01 = 10'b0010101011;
    localparam logic [9:0] T10 = 10'b0101010100;
    localparam logic [9:0] T11 = 10'b1010101011;

    typedef struct {
        logic       ve;
        logic [7:0] d;
        logic [1:0] c;
    } exp_t;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic [9:0] tmds_in = '0;
    logic [7:0] data_out;
    logic [1:0] control_out;
    logic       ve_out;
    logic       valid_out;
    logic [3:0] slip_out;
    logic [7:0] lock_loss_out;

    exp_t       sb[$];
    int         n_chk = 0;
    int         n_err = 0;
    int         rot = 0;
    int         disp = 0;
    int         exp_slip;
    int         exp_loss;
    logic [9:0] last_e = '0;
    logic [1:0] cur_c = '0;
    bit         sb_on = 1'b0;

    tmds_decoder #(
        .CTRL_LOCK_COUNT(CLC),
        .SEARCH_WINDOW  (SW),
        .LOCK_TIMEOUT   (LT)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .tmds_in      (tmds_in),
        .data_out     (data_out),
        .control_out  (control_out),
        .ve_out       (ve_out),
        .valid_out    (valid_out),
        .slip_out     (slip_out),
        .lock_loss_out(lock_loss_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [9:0] tok(input logic [1:0] c);
        return (c == 2'b00) ? T00 : (c == 2'b01) ? T01 : (c == 2'b10) ? T10 : T11;
    endfunction

    // DVI transmit encoder with running disparity
    function automatic logic [9:0] enc(input logic [7:0] d);
        logic [8:0] qm;
        logic [9:0] r;
        logic       xn;
        int         nq;
        xn = ($countones(d) > 4) || ($countones(d) == 4 && !d[0]);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = ~xn;
        nq = $countones(qm[7:0]);
        if (disp == 0 || nq == 4) begin
            r = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            disp += qm[8] ? (2 * nq - 8) : (8 - 2 * nq);
        end else if ((disp > 0 && nq > 4) || (disp < 0 && nq < 4)) begin
            r = {1'b1, qm[8], ~qm[7:0]};
            disp += 2 * int'(qm[8]) + (8 - 2 * nq);
        end else begin
            r = {1'b0, qm[8], qm[7:0]};
            disp += -2 * int'(!qm[8]) + (2 * nq - 8);
        end
        return r;
    endfunction

    // one clock: serialise word e behind the previous one at bit rotation rot, then pop when due
    task automatic cyc(input logic [9:0] e, input exp_t x);
        logic [19:0] s;
        exp_t        o;
        s = {e, last_e};
        tmds_in = 10'(s >> (10 - rot));
        last_e = e;
        if (sb_on) sb.push_back(x);
        @(posedge clk_in);
        #1;
        if (sb.size() == 3) begin
            o = sb.pop_front();
            chk("sb_ve", 32'(ve_out), 32'(o.ve));
            if (o.ve) chk("sb_data", 32'(data_out), 32'(o.d));
            else      chk("sb_ctrl", 32'(control_out), 32'(o.c));
            chk("sb_valid", 32'(valid_out), 32'd1);
        end
    endtask

    task automatic send_data(input logic [7:0] b);
        cyc(enc(b), exp_t'{1'b1, b, cur_c});
    endtask

    task automatic send_tok(input logic [1:0] c);
        disp = 0;
        cur_c = c;
        cyc(tok(c), exp_t'{1'b0, 8'h00, c});
    endtask

    task automatic lock(input string tag, input logic [1:0] c, input int bound);
        for (int i = 0; i < bound && !valid_out; i++) send_tok(c);
        chk(tag, 32'(valid_out), 32'd1);
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        last_e = '0;
        disp = 0;
    endtask

    initial begin
        #1 rst_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_ctrl", 32'(control_out), 32'd0);
        chk("rst_ve", 32'(ve_out), 32'd0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_slip", 32'(slip_out), 32'd0);
        chk("rst_loss", 32'(lock_loss_out), 32'd0);
        rst_in = 1'b1;

        // run of 8 tokens completes on the same edge the first window expires
        rot = 0;
        for (int m = 1; m < SW; m++)
            if (m >= SW - 9 && m <= SW - 2) send_tok(2'b00); else send_data(8'(m));
        chk("bnd_pre_valid", 32'(valid_out), 32'd0);
        chk("bnd_pre_slip", 32'(slip_out), 32'd0);
        send_data(8'h33);
        chk("bnd_valid", 32'(valid_out), 32'd1);
        chk("bnd_slip", 32'(slip_out), 32'd0);

        // control decode while locked
        repeat (10) send_tok(2'b10);
        chk("ctl10", 32'(control_out), 32'd2);
        chk("ctl10_valid", 32'(valid_out), 32'd1);
        repeat (10) send_tok(2'b01);
        chk("ctl01", 32'(control_out), 32'd1);
        repeat (10) send_tok(2'b11);
        chk("ctl11", 32'(control_out), 32'd3);
        chk("ctl11_valid", 32'(valid_out), 32'd1);

        // lock loss after LT data words
        for (int i = 0; i < LT + 1; i++) send_data(8'($urandom_range(0, 255)));
        chk("loss_pre_valid", 32'(valid_out), 32'd1);
        chk("loss_pre_ve", 32'(ve_out), 32'd1);
        send_data(8'h5A);
        chk("loss_valid", 32'(valid_out), 32'd0);
        chk("loss_ve", 32'(ve_out), 32'd0);
        chk("loss_count", 32'(lock_loss_out), 32'd1);
        chk("loss_slip", 32'(slip_out), 32'd1);

        // relock at slip 1, then asynchronous reset mid-cycle
        rot = 1;
        lock("relock1", 2'b11, 40);
        chk("relock1_slip", 32'(slip_out), 32'd1);
        @(posedge clk_in);
        #2 rst_in = 1'b0;
        #1;
        chk("arst_data", 32'(data_out), 32'd0);
        chk("arst_ctrl", 32'(control_out), 32'd0);
        chk("arst_ve", 32'(ve_out), 32'd0);
        chk("arst_valid", 32'(valid_out), 32'd0);
        chk("arst_slip", 32'(slip_out), 32'd0);
        chk("arst_loss", 32'(lock_loss_out), 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        rot = 0;
        last_e = '0;
        lock("relock0", 2'b01, 40);
        chk("relock0_slip", 32'(slip_out), 32'd0);
        chk("relock0_ctrl", 32'(control_out), 32'd1);

        // encoder loopback at rotation 3
        do_reset();
        rot = 3;
        lock("lb_lock", 2'b00, 10 * SW + 20);
        chk("lb_slip", 32'(slip_out), 32'd3);
        chk("lb_ctrl", 32'(control_out), 32'd0);
        chk("lb_ve", 32'(ve_out), 32'd0);
        sb_on = 1'b1;
        for (int k = 0; k < 4; k++) begin
            for (int b = 0; b < 64; b++) send_data(8'(k * 64 + b));
            repeat (12) send_tok(2'(k));
        end
        sb_on = 1'b0;
        sb.delete();

        // search sweep on random words
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            repeat (SW - 1) cyc(10'($urandom_range(0, 1023)), exp_t'{1'b0, 8'h00, 2'b00});
            chk("sweep_hold", 32'(slip_out), 32'((k - 1) % 10));
            cyc(10'($urandom_range(0, 1023)), exp_t'{1'b0, 8'h00, 2'b00});
            chk("sweep_step", 32'(slip_out), 32'(k % 10));
            chk("sweep_valid", 32'(valid_out), 32'd0);
        end

        // lock_loss_out saturation
        do_reset();
        exp_slip = 0;
        exp_loss = 0;
        for (int i = 0; i < 300; i++) begin
            rot = exp_slip;
            lock("sat_lock", 2'b00, 40);
            repeat (LT + 4) send_data(8'($urandom_range(0, 255)));
            exp_slip = (exp_slip + 1) % 10;
            exp_loss = (exp_loss == 255) ? 255 : exp_loss + 1;
            chk("sat_loss", 32'(lock_loss_out), 32'(exp_loss));
            chk("sat_slip", 32'(slip_out), 32'(exp_slip));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
